// File: rtl/modsq_pkg.sv
// ============================================================================
//  Module   : modsq_pkg
//  Brief    : Shared types and defaults for the modular-squaring sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package modsq_pkg;

    localparam int MOD_LEN_DEF = 1024;
    localparam int ITER_W_DEF  = 40;
    localparam int TO_W_DEF    = 24;

    typedef logic [ITER_W_DEF-1:0] iter_t;
    typedef logic [TO_W_DEF-1:0]   timeout_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5,
        ST_DRAIN   = 3'd6
    } seq_state_t;

endpackage : modsq_pkg

`default_nettype wire

// File: rtl/modsq_iter_sequencer_sync.sv
// ============================================================================
//  Module   : toggle_edge_sync
//  Brief    : Synchronises a cross-domain toggle and emits a 1-cycle pulse
//             for every toggle edge. Also serves the core-side start path.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module toggle_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic toggle_in,
    output logic pulse
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;
    logic                                            r_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_last <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], toggle_in};
            r_last <= r_sync[SYNC_STAGES-1];
        end
    end

    assign pulse = r_sync[SYNC_STAGES-1] ^ r_last;

endmodule : toggle_edge_sync

`default_nettype wire

// File: rtl/modsq_iter_sequencer.sv
// ============================================================================
//  Module   : modsq_iter_sequencer
//  Brief    : Runs back-to-back modular squarings on a toggle-handshake core,
//             with per-iteration timeout, abort/drain and checkpoints.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module modsq_iter_sequencer
    import modsq_pkg::*;
#(
    parameter int MOD_LEN     = MOD_LEN_DEF,
    parameter int ITER_W      = ITER_W_DEF,
    parameter int TO_W        = TO_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int CKPT_LOG2   = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_start,
    input  logic               cmd_abort,
    input  logic [ITER_W-1:0]  cfg_iters,
    input  logic [TO_W-1:0]    cfg_timeout,
    input  logic [MOD_LEN-1:0] x_in,
    output logic [MOD_LEN-1:0] sq_in,
    output logic               start_toggle,
    input  logic [MOD_LEN-1:0] sq_out_i,
    input  logic               valid_toggle_i,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic               ckpt_valid,
    output logic [ITER_W-1:0]  iter_count,
    output logic [MOD_LEN-1:0] y_out
);

    seq_state_t        r_state;
    logic [ITER_W-1:0] r_iters_cfg;
    logic [TO_W-1:0]   r_timeout_cfg;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_outstanding;

    logic              w_vpulse;
    logic              w_pending;
    logic [ITER_W-1:0] w_count_inc;
    logic              w_ckpt_hit;

    toggle_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_valid_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .toggle_in (valid_toggle_i),
        .pulse     (w_vpulse)
    );

    // A toggle is still owed by the core unless it lands this very cycle.
    assign w_pending   = r_outstanding & ~w_vpulse;
    assign w_count_inc = iter_count + ITER_W'(1);
    assign w_ckpt_hit  = (w_count_inc[CKPT_LOG2-1:0] == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_iters_cfg   <= '0;
            r_timeout_cfg <= '0;
            r_to_cnt      <= '0;
            r_outstanding <= 1'b0;
            sq_in         <= '0;
            y_out         <= '0;
            iter_count    <= '0;
            start_toggle  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            ckpt_valid    <= 1'b0;
        end else begin
            done       <= 1'b0;
            ckpt_valid <= 1'b0;
            if (w_vpulse) begin
                r_outstanding <= 1'b0;
            end

            if (cmd_abort && r_state != ST_IDLE) begin
                r_state <= w_pending ? ST_DRAIN : ST_IDLE;
                busy    <= w_pending;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cmd_start) begin
                            r_iters_cfg   <= cfg_iters;
                            r_timeout_cfg <= cfg_timeout;
                            sq_in         <= x_in;
                            y_out         <= x_in;
                            iter_count    <= '0;
                            timeout_err   <= 1'b0;
                            busy          <= 1'b1;
                            r_state       <= (cfg_iters == '0) ? ST_DONE : ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        start_toggle  <= ~start_toggle;
                        r_outstanding <= 1'b1;
                        r_to_cnt      <= r_timeout_cfg;
                        r_state       <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (w_vpulse) begin
                            r_state <= ST_CAPTURE;
                        end else if (r_timeout_cfg != '0) begin
                            r_to_cnt <= r_to_cnt - TO_W'(1);
                            if (r_to_cnt == TO_W'(1)) begin
                                timeout_err <= 1'b1;
                                r_state     <= ST_ERR;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        y_out      <= sq_out_i;
                        sq_in      <= sq_out_i;
                        iter_count <= w_count_inc;
                        ckpt_valid <= w_ckpt_hit;
                        r_state    <= (w_count_inc == r_iters_cfg) ? ST_DONE : ST_ISSUE;
                    end
                    ST_DONE: begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    ST_ERR: begin
                        timeout_err <= 1'b1;
                        r_state     <= w_pending ? ST_DRAIN : ST_IDLE;
                        busy        <= w_pending;
                    end
                    ST_DRAIN: begin
                        if (w_vpulse) begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A core completion outside WAIT/DRAIN means the handshake lost track.
    always @(posedge clk) begin
        if (reset_n) begin
            assert (!w_vpulse || r_state == ST_WAIT || r_state == ST_DRAIN);
        end
    end

endmodule : modsq_iter_sequencer

`default_nettype wire
